prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_word_pack.sv | 50 +++++
 rtl/prog_loader.sv | 120 ++++++++++++
 tb/tb_prog_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, header/checksum widths
// and a small state-decode helper.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COUNT_HI = 3'd1,
      ST_COUNT_LO = 3'd2,
      ST_DATA     = 3'd3,
      ST_CSUM     = 3'd4,
      ST_DONE     = 3'd5,
      ST_ERROR    = 3'd6
   } state_t;

   localparam int HDR_W  = 16;
   localparam int CSUM_W = 8;

   // States in which the loader is willing to consume stream bytes
   function automatic logic takes_bytes(state_t s);
      return (s == ST_COUNT_HI) || (s == ST_COUNT_LO) ||
             (s == ST_DATA)     || (s == ST_CSUM);
   endfunction

   function automatic logic can_start(state_t s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
   endfunction

endpackage

// File: rtl/prog_loader_word_pack.sv
// Packs a byte stream MSB-first into words; pulses word_valid the cycle after the
// final byte of a word is taken, with the complete word held on word.
module word_pack #(
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_in,
   output logic                 last_byte,
   output logic [WORD_SIZE-1:0] word,
   output logic                 word_valid
);

   localparam int BPW = WORD_SIZE / 8;
   localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [WORD_SIZE-1:0] shift_reg;
   logic [WORD_SIZE-1:0] shift_next;
   logic [CW-1:0]        byte_cnt;

   assign shift_next = (shift_reg << 8) | WORD_SIZE'(byte_in);
   assign last_byte  = (byte_cnt == CW'(BPW - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_reg  <= '0;
         byte_cnt   <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
         end else if (byte_valid) begin
            shift_reg <= shift_next;
            if (last_byte) begin
               byte_cnt   <= '0;
               word       <= shift_next;
               word_valid <= 1'b1;
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into the instruction
// memory write port and releases the core only after a clean load.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_SIZE = 10,
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 we,
   output logic [ADDR_SIZE-1:0] waddr,
   output logic [WORD_SIZE-1:0] wdata,
   output logic                 core_hold,
   output logic                 done,
   output logic                 error
);

   localparam logic [63:0] MAX_WORDS = 64'd1 << ADDR_SIZE;

   state_t              state;
   state_t              state_next;
   logic [HDR_W-1:0]    count_reg;
   logic [HDR_W-1:0]    word_cnt;
   logic [CSUM_W-1:0]   csum_reg;
   logic                accept;
   logic                start_load;
   logic                last_byte;
   logic                last_word;
   logic [HDR_W-1:0]    n_full;

   assign accept     = in_valid && in_ready;
   assign start_load = start && can_start(state);
   assign n_full     = {count_reg[HDR_W-1:8], in_data};
   assign last_word  = (word_cnt == count_reg - 16'd1);

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR:
            if (start) state_next = ST_COUNT_HI;
         ST_COUNT_HI:
            if (accept) state_next = ST_COUNT_LO;
         ST_COUNT_LO:
            if (accept) begin
               if (n_full == '0)
                  state_next = ST_CSUM;
               else if (64'(n_full) > MAX_WORDS)
                  state_next = ST_ERROR;
               else
                  state_next = ST_DATA;
            end
         ST_DATA:
            if (accept && last_byte && last_word) state_next = ST_CSUM;
         ST_CSUM:
            if (accept) state_next = (in_data == csum_reg) ? ST_DONE : ST_ERROR;
         default:
            state_next = ST_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         core_hold <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         count_reg <= '0;
         word_cnt  <= '0;
         csum_reg  <= '0;
         waddr     <= '0;
      end else begin
         state     <= state_next;
         in_ready  <= takes_bytes(state_next);
         core_hold <= (state_next != ST_DONE);
         done      <= (state_next == ST_DONE);
         error     <= (state_next == ST_ERROR);
         if (start_load) begin
            count_reg <= '0;
            word_cnt  <= '0;
            csum_reg  <= '0;
            waddr     <= '0;
         end else if (accept) begin
            case (state)
               ST_COUNT_HI: count_reg[HDR_W-1:8] <= in_data;
               ST_COUNT_LO: count_reg[7:0]       <= in_data;
               ST_DATA: begin
                  csum_reg <= csum_reg ^ in_data;
                  if (last_byte) begin
                     // waddr holds the index of the word about to be strobed out
                     waddr    <= ADDR_SIZE'(word_cnt);
                     word_cnt <= word_cnt + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   word_pack #(
      .WORD_SIZE (WORD_SIZE)
   ) u_word_pack (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_load),
      .byte_valid (accept && (state == ST_DATA)),
      .byte_in    (in_data),
      .last_byte  (last_byte),
      .word       (wdata),
      .word_valid (we)
   );

endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized bench for prog_loader against a byte-stream reference model.
module tb_prog_loader;

   localparam int AW  = 10;
   localparam int WW  = 32;
   localparam int BPW = WW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [WW-1:0] wdata;
   logic          core_hold;
   logic          done;
   logic          error;

   int checks = 0;
   int failures = 0;

   logic [7:0]    data_q[$];
   logic [AW-1:0] wa_q[$];
   logic [WW-1:0] wd_q[$];

   prog_loader #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
      .core_hold(core_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we) begin
         wa_q.push_back(waddr);
         wd_q.push_back(wdata);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offers one byte, optionally after idle gaps and with start noise, until taken.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
      int tmo;
      int idle;
      idle = (gap > 0) ? $urandom_range(0, gap) : 0;
      for (int i = 0; i < idle; i++) begin
         in_valid = 1'b0;
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = b;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tmo = 0;
      while (!in_ready && tmo < 200) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 200) check("ready_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      start = 1'b0;
   endtask

   function automatic logic [7:0] model_csum();
      logic [7:0] c = 8'h00;
      foreach (data_q[i]) c ^= data_q[i];
      return c;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Full load of data_q with header n; csum byte is the true XOR unless forced.
   task automatic load(input int n, input bit good, input logic [7:0] forced,
                       input int gap, input bit noise);
      logic [15:0] nn;
      nn = 16'(n);
      wa_q.delete();
      wd_q.delete();
      pulse_start();
      send_byte(nn[15:8], gap, 1'b0);
      send_byte(nn[7:0], gap, 1'b0);
      foreach (data_q[i]) send_byte(data_q[i], gap, noise);
      send_byte(good ? model_csum() : forced, gap, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_writes(input string tag, input int n);
      logic [WW-1:0] w;
      check({tag, "_wcount"}, 64'(wa_q.size()), 64'(n));
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         w = '0;
         for (int k = 0; k < BPW; k++) w = (w << 8) | WW'(data_q[i*BPW + k]);
         check({tag, "_waddr"}, 64'(wa_q[i]), 64'(i));
         check({tag, "_wdata"}, 64'(wd_q[i]), 64'(w));
      end
   endtask

   task automatic check_status(input string tag, input bit d, input bit e);
      check({tag, "_done"}, 64'(done), 64'(d));
      check({tag, "_error"}, 64'(error), 64'(e));
      check({tag, "_hold"}, 64'(core_hold), 64'(!d));
      check({tag, "_ready"}, 64'(in_ready), 64'd0);
   endtask

   task automatic fill_random(input int nbytes);
      data_q.delete();
      for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"}, 64'(we), 64'd0);
      check({tag, "_waddr"}, 64'(waddr), 64'd0);
      check({tag, "_wdata"}, 64'(wdata), 64'd0);
      check({tag, "_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold"}, 64'(core_hold), 64'd1);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_error"}, 64'(error), 64'd0);
   endtask

   initial begin
      logic [15:0] big;
      int n;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_ready", 64'(in_ready), 64'd0);
      check("idle_hold", 64'(core_hold), 64'd1);
      check("idle_nowrite", 64'(wa_q.size()), 64'd0);
      $display("step reset/idle checked");

      data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      check("model_csum", 64'(model_csum()), 64'h88);
      load(2, 1'b1, 8'h00, 0, 1'b0);
      check_writes("n2", 2);
      check_status("n2", 1'b1, 1'b0);
      $display("step N=2 good checksum: writes=%0d done=%0d", wa_q.size(), done);

      load(2, 1'b0, 8'h00, 0, 1'b0);
      check_writes("n2bad", 2);
      check_status("n2bad", 1'b0, 1'b1);
      $display("step N=2 bad checksum: writes=%0d error=%0d", wa_q.size(), error);

      data_q.delete();
      load(0, 1'b1, 8'h00, 0, 1'b0);
      check_writes("n0", 0);
      check_status("n0", 1'b1, 1'b0);
      $display("step N=0: writes=%0d done=%0d", wa_q.size(), done);

      wa_q.delete();
      wd_q.delete();
      big = 16'h0401;
      pulse_start();
      send_byte(big[15:8], 0, 1'b0);
      send_byte(big[7:0], 0, 1'b0);
      check_status("n401", 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      check("n401_nowrite", 64'(wa_q.size()), 64'd0);
      $display("step N=0x401 overflow: error=%0d", error);

      fill_random(1024 * BPW);
      load(1024, 1'b1, 8'h00, 0, 1'b0);
      check_writes("n1024", 1024);
      check_status("n1024", 1'b1, 1'b0);
      $display("step N=1024 boundary: writes=%0d done=%0d", wa_q.size(), done);

      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 8);
         fill_random(n * BPW);
         load(n, 1'b1, 8'h00, 3, 1'b1);
         check_writes("rand", n);
         check_status("rand", 1'b1, 1'b0);
         $display("step random load %0d N=%0d writes=%0d done=%0d", it, n, wa_q.size(), done);
      end

      fill_random(3 * BPW);
      wa_q.delete();
      wd_q.delete();
      pulse_start();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h03, 0, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(data_q[i], 0, 1'b0);
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (4) @(negedge clk);
      check_writes("midrst", 1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_idle", 64'(in_ready), 64'd0);
      $display("step reset mid-load: writes=%0d", wa_q.size());

      fill_random(BPW);
      load(1, 1'b1, 8'h00, 1, 1'b0);
      check_writes("reload", 1);
      check_status("reload", 1'b1, 1'b0);
      $display("step reload after reset: writes=%0d done=%0d", wa_q.size(), done);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
